// File: rtl/alu_exec_unit_if.sv
// Operation request / result handshake bundle for alu_exec_unit.
// master drives requests and consumes results; slave is the execution unit.
interface alu_exec_unit_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   modport master (
      output in_valid, alu_ctrl, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alu_ctrl, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with registered result and valid/ready handshake.
// Define ALU_BARREL_SHIFT_EN for single-cycle shifts; otherwise SLLV/SRLV shift one bit per cycle.
module alu_exec_unit (
   input  logic           clk,
   input  logic           reset,
   alu_exec_unit_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
`ifndef ALU_BARREL_SHIFT_EN
   localparam logic [1:0] SHIFT = 2'd1;
`endif
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]  state;
   logic [31:0] result_q;
   logic        zero_q;
   logic        illegal_q;
   logic [31:0] op_res;
   logic        op_illegal;
   logic [4:0]  shamt;

`ifndef ALU_BARREL_SHIFT_EN
   logic [31:0] work;
   logic [31:0] work_next;
   logic [4:0]  count;
   logic        dir_right;
   logic        is_shift;
`endif

   assign shamt = bus.src_a[4:0];

   always_comb begin
      op_res     = '0;
      op_illegal = 1'b0;
      case (bus.alu_ctrl)
         4'b0000: op_res = bus.src_a & bus.src_b;
         4'b0001: op_res = bus.src_a | bus.src_b;
         4'b0010: op_res = bus.src_a + bus.src_b;
         4'b0110: op_res = bus.src_a - bus.src_b;
         4'b0111: op_res = {31'b0, ($signed(bus.src_a) < $signed(bus.src_b))};
         4'b1000: op_res = bus.src_a ^ bus.src_b;
         4'b1001: op_res = ~(bus.src_a | bus.src_b);
`ifdef ALU_BARREL_SHIFT_EN
         4'b1010: op_res = bus.src_b << shamt;
         4'b1011: op_res = bus.src_b >> shamt;
`else
         // Only reached here with a zero shift amount; nonzero amounts iterate in SHIFT.
         4'b1010,
         4'b1011: op_res = bus.src_b;
`endif
         default: op_illegal = 1'b1;
      endcase
   end

`ifndef ALU_BARREL_SHIFT_EN
   assign is_shift  = (bus.alu_ctrl == 4'b1010) || (bus.alu_ctrl == 4'b1011);
   assign work_next = dir_right ? (work >> 1) : (work << 1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
         work      <= '0;
         count     <= '0;
         dir_right <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                  if (is_shift && (shamt != 5'd0)) begin
                     work      <= bus.src_b;
                     count     <= shamt;
                     dir_right <= bus.alu_ctrl[0];
                     state     <= SHIFT;
                  end else
`endif
                  begin
                     result_q  <= op_res;
                     zero_q    <= (op_res == '0);
                     illegal_q <= op_illegal;
                     state     <= DONE;
                  end
               end
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
               work  <= work_next;
               count <= count - 5'd1;
               if (count == 5'd1) begin
                  result_q  <= work_next;
                  zero_q    <= (work_next == '0);
                  illegal_q <= 1'b0;
                  state     <= DONE;
               end
            end
`endif
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = illegal_q;
endmodule
